// File: rtl/rpsc_pkg.sv
// rpsc_pkg: shared types and constants for the power-supply sequencer cards.
//   seq_state_t        sequencer states
//   trip_cause_t       latched trip causes reported to the operator panel
//   RPSC_TICKS_PER_SEC interlock tick rate
//   max2               integer max, used to size the timers
package rpsc_pkg;

    typedef enum logic [2:0] {
        OFF, FAN_UP, G1_EN, CA_START, RUN, TRIP, COOLDOWN
    } seq_state_t;

    typedef enum logic [3:0] {
        NONE, FAN_TO, PERM_TO, OK_TO, STATUS, I_HIGH, U_LOW, CA_NOK, FAN_LOST
    } trip_cause_t;

    localparam int RPSC_TICKS_PER_SEC = 64;

    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/sec_timer.sv
// sec_timer: loadable down-counter that stops at zero.
//   clk, reset  clock, asynchronous active-low reset (clears the count)
//   load        load value this cycle instead of counting
//   value       load value (duration in ticks minus one)
//   expired     count has reached zero
module sec_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;

    assign expired = cnt == '0;

endmodule

// File: rtl/ca_ps_sequencer.sv
// ca_ps_sequencer: CA power-supply start/run/trip/cooldown sequencer in front of card 1.
//   clk, reset                 interlock clock, asynchronous active-low reset
//   start_req/stop_req/ack_req operator panel levels (stop dominates start)
//   fan_running, i55/i47/i74/i75/i70/i77  fan tacho and card-1 feedback
//   o54_FAN_ON, o53_Not_G1_OK, o59_CA_PS_ACT  requests into card 1
//   o_state, o_trip, o_trip_cause, o_running  panel status
module ca_ps_sequencer
    import rpsc_pkg::*;
#(
    parameter int TICKS_PER_SEC = RPSC_TICKS_PER_SEC,
    parameter int FAN_SPIN_S    = 5,
    parameter int PERM_TO_S     = 10,
    parameter int OK_TO_S       = 70,
    parameter int COOL_S        = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_req,
    input  logic        stop_req,
    input  logic        ack_req,
    input  logic        fan_running,
    input  logic        i55_Not_Alarm,
    input  logic        i47_CA_ON_PERM_n,
    input  logic        i74_CA_Delay,
    input  logic        i75_Not_CA_OK,
    input  logic        i70_I_CA_High_n,
    input  logic        i77_U_CA_Low_n,
    output logic        o54_FAN_ON,
    output logic        o53_Not_G1_OK,
    output logic        o59_CA_PS_ACT,
    output seq_state_t  o_state,
    output logic        o_trip,
    output trip_cause_t o_trip_cause,
    output logic        o_running
);

    localparam int TMAX = max2(max2(FAN_SPIN_S, PERM_TO_S), max2(OK_TO_S, COOL_S)) * TICKS_PER_SEC;
    localparam int TW   = $clog2(TMAX + 1);

    seq_state_t    state, nxt;
    trip_cause_t   ilk, flt, tmo, tc, cause;
    logic          adv, expired;
    logic [TW-1:0] tval;

    sec_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (nxt != state),
        .value   (tval),
        .expired (expired)
    );

    always_comb begin
        ilk = !i55_Not_Alarm ? STATUS : !i70_I_CA_High_n ? I_HIGH : !i77_U_CA_Low_n ? U_LOW : NONE;
        flt = NONE;
        tmo = NONE;
        adv = 1'b0;
        // FAN_LOST is not checked in FAN_UP: the fan is still spinning up there,
        // and a missing tacho is reported as FAN_TO when the timer runs out.
        case (state)
            FAN_UP: begin
                flt = ilk;
                tmo = FAN_TO;
                adv = fan_running;
            end
            G1_EN: begin
                flt = ilk != NONE ? ilk : fan_running ? NONE : FAN_LOST;
                tmo = PERM_TO;
                adv = !i47_CA_ON_PERM_n;
            end
            CA_START: begin
                flt = ilk != NONE ? ilk : fan_running ? NONE : FAN_LOST;
                tmo = OK_TO;
                adv = !i75_Not_CA_OK && i74_CA_Delay;
            end
            RUN: flt = ilk != NONE ? ilk : i75_Not_CA_OK ? CA_NOK : fan_running ? NONE : FAN_LOST;
            default: ;
        endcase
        // Feedback arriving in the expiry cycle still counts as in time; a timeout beats stop.
        tc = flt != NONE ? flt : (expired && !adv) ? tmo : NONE;
        nxt = state;
        case (state)
            OFF:      if (start_req && !stop_req && !o_trip) nxt = FAN_UP;
            FAN_UP, G1_EN, CA_START, RUN:
                nxt = tc != NONE ? TRIP : stop_req ? COOLDOWN : adv ? seq_state_t'(state + 3'd1) : state;
            TRIP:     nxt = COOLDOWN;
            COOLDOWN: if (expired) nxt = OFF;
            default:  nxt = OFF;
        endcase
        tval = nxt == FAN_UP   ? TW'(FAN_SPIN_S * TICKS_PER_SEC - 1) :
               nxt == G1_EN    ? TW'(PERM_TO_S * TICKS_PER_SEC - 1) :
               nxt == CA_START ? TW'(OK_TO_S * TICKS_PER_SEC - 1) :
               nxt == COOLDOWN ? TW'(COOL_S * TICKS_PER_SEC - 1) : '0;
    end

    assign o_state = state;

    // Card-1 requests are decoded from the current state, so they follow it by one clk.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state         <= OFF;
            cause         <= NONE;
            o54_FAN_ON    <= 1'b0;
            o53_Not_G1_OK <= 1'b1;
            o59_CA_PS_ACT <= 1'b0;
            o_running     <= 1'b0;
            o_trip        <= 1'b0;
            o_trip_cause  <= NONE;
        end else begin
            state         <= nxt;
            if (nxt == TRIP) cause <= tc;
            o54_FAN_ON    <= state != OFF;
            o53_Not_G1_OK <= !(state inside {G1_EN, CA_START, RUN});
            o59_CA_PS_ACT <= state inside {CA_START, RUN};
            o_running     <= state == RUN;
            if (state == TRIP) begin
                o_trip <= 1'b1;
                if (o_trip_cause == NONE) o_trip_cause <= cause;
            end else if (state == OFF && ack_req) begin
                o_trip       <= 1'b0;
                o_trip_cause <= NONE;
            end
        end

endmodule
